// File: rtl/write_stream_if.sv
// Handshake/bus bundle between a stream producer, the write_stream engine and the MEM write port.
// The master side configures jobs and supplies data; the slave side is the write engine.
interface write_stream_if #(
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 8,
  parameter int LOG_MAX_WRITES_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS         = 12
) ();
  logic                               configure;
  logic [LOG_MAX_ITERS-1:0]           num_iters;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]         base_address;
  logic                               valid_in;
  logic [DATA_WIDTH-1:0]              data_in;
  logic                               avail_out;
  logic                               write;
  logic [LOG_MAX_ADDRESS-1:0]         addr_write;
  logic [DATA_WIDTH-1:0]              data_write;
  logic                               done;

  modport master (
    output configure, num_iters, num_writes_per_iter, base_address, valid_in, data_in,
    input  avail_out, write, addr_write, data_write, done
  );

  modport slave (
    input  configure, num_iters, num_writes_per_iter, base_address, valid_in, data_in,
    output avail_out, write, addr_write, data_write, done
  );
endinterface

// File: rtl/write_stream.sv
// Stream-to-memory writer: accepts valid/avail words and issues sequential MEM writes
// for num_iters x num_writes_per_iter words starting at base_address, then pulses done.
module write_stream #(
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 8,
  parameter int LOG_MAX_WRITES_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS         = 12
) (
  input  logic          clk,
  input  logic          rst,
  write_stream_if.slave bus
);

  localparam logic [LOG_MAX_ADDRESS-1:0]         ADDR_ONE = {{(LOG_MAX_ADDRESS-1){1'b0}}, 1'b1};
  localparam logic [LOG_MAX_ITERS-1:0]           ITER_ONE = {{(LOG_MAX_ITERS-1){1'b0}}, 1'b1};
  localparam logic [LOG_MAX_WRITES_PER_ITER-1:0] WORD_ONE = {{(LOG_MAX_WRITES_PER_ITER-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t state, state_next;

  logic [LOG_MAX_ITERS-1:0]           iters_q, iter_cnt;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_q, word_cnt;
  logic [LOG_MAX_ADDRESS-1:0]         pointer;
  logic                               write_q, done_q;
  logic [LOG_MAX_ADDRESS-1:0]         addr_q;
  logic [DATA_WIDTH-1:0]              data_q;
  logic                               accept, iter_end, last_word, start;

  assign start     = (state == IDLE) && bus.configure;
  assign accept    = (state == RUN) && bus.valid_in;
  assign iter_end  = (word_cnt == writes_q - WORD_ONE);
  assign last_word = iter_end && (iter_cnt == iters_q - ITER_ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.configure) begin
          if ((bus.num_iters == '0) || (bus.num_writes_per_iter == '0)) state_next = ZERO;
          else                                                          state_next = RUN;
        end
      end
      RUN:     if (accept && last_word) state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write strobe and done are registered from the accept, so the final write and done share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      iters_q  <= '0;
      writes_q <= '0;
      iter_cnt <= '0;
      word_cnt <= '0;
      pointer  <= '0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      write_q <= accept;
      done_q  <= (state == ZERO) || (accept && last_word);
      if (start) begin
        iters_q  <= bus.num_iters;
        writes_q <= bus.num_writes_per_iter;
        pointer  <= bus.base_address;
        iter_cnt <= '0;
        word_cnt <= '0;
      end
      if (accept) begin
        addr_q  <= pointer;
        data_q  <= bus.data_in;
        pointer <= pointer + ADDR_ONE;
        if (iter_end) begin
          word_cnt <= '0;
          iter_cnt <= iter_cnt + ITER_ONE;
        end else begin
          word_cnt <= word_cnt + WORD_ONE;
        end
      end
    end
  end

  assign bus.avail_out  = (state == RUN);
  assign bus.write      = write_q;
  assign bus.addr_write = addr_q;
  assign bus.data_write = data_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_write_stream.sv
// Scoreboard bench for write_stream: stimulus pushes expected write/done events,
// a negedge monitor pops and compares them whenever the DUT writes or signals done.
module tb_write_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [7:0]  d;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];

  write_stream_if #(.DATA_WIDTH(8), .LOG_MAX_ITERS(8), .LOG_MAX_WRITES_PER_ITER(16), .LOG_MAX_ADDRESS(12)) bus ();

  write_stream #(.DATA_WIDTH(8), .LOG_MAX_ITERS(8), .LOG_MAX_WRITES_PER_ITER(16), .LOG_MAX_ADDRESS(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_expected(input logic [11:0] base, input int words,
                                        input logic [7:0] seed, input int limit);
    exp_t e;
    for (int k = 0; k < limit; k++) begin
      e.w  = 1'b1;
      e.a  = base + 12'(k);
      e.d  = seed + 8'(k);
      e.dn = (k == words - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: every write or done cycle must match the next expected event.
  always @(negedge clk) begin
    if (bus.write || bus.done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_event", {bus.write, bus.done}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("sb_write", bus.write, e.w);
        check_output("sb_done", bus.done, e.dn);
        if (e.w) begin
          check_output("sb_addr", bus.addr_write, e.a);
          check_output("sb_data", bus.data_write, e.d);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [11:0] base, input logic [7:0] ni, input logic [15:0] nw);
    bus.configure           = 1'b1;
    bus.base_address        = base;
    bus.num_iters           = ni;
    bus.num_writes_per_iter = nw;
    @(posedge clk); #1;
    bus.configure = 1'b0;
  endtask

  task automatic run_stream(input int start, input int n, input bit gap,
                            input logic [7:0] seed, output int cycles);
    int  got = start;
    int  cyc = 0;
    bit  acc;
    while (got < start + n && cyc < 1000) begin
      if (!gap || (cyc % 2 == 0)) begin
        bus.valid_in = 1'b1;
        bus.data_in  = seed + 8'(got);
      end else begin
        bus.valid_in = 1'b0;
        bus.data_in  = 8'hEE;
      end
      @(negedge clk);
      acc = bus.valid_in && bus.avail_out;
      @(posedge clk); #1;
      if (acc) got++;
      cyc++;
    end
    if (got < start + n) check_output("stream_timeout", got, start + n);
    bus.valid_in = 1'b0;
    cycles = cyc;
  endtask

  task automatic zero_job(input logic [7:0] ni, input logic [15:0] nw);
    exp_t e;
    e.w = 1'b0; e.a = '0; e.d = '0; e.dn = 1'b1;
    exp_q.push_back(e);
    apply_stimulus(12'd7, ni, nw);
    bus.valid_in = 1'b1;
    @(negedge clk);
    check_output("zero_done_early", bus.done, 1'b0);
    check_output("zero_avail1", bus.avail_out, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("zero_done", bus.done, 1'b1);
    check_output("zero_avail2", bus.avail_out, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("zero_done_once", bus.done, 1'b0);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.configure           = 1'b0;
    bus.num_iters           = '0;
    bus.num_writes_per_iter = '0;
    bus.base_address        = '0;
    bus.valid_in            = 1'b0;
    bus.data_in             = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_avail", bus.avail_out, 1'b0);
    check_output("rst_write", bus.write, 1'b0);
    check_output("rst_addr", bus.addr_write, 12'd0);
    check_output("rst_data", bus.data_write, 8'd0);
    check_output("rst_done", bus.done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Base job: 4x16 from address 32, continuous valid.
    push_expected(12'd32, 64, 8'h00, 64);
    apply_stimulus(12'd32, 8'd4, 16'd16);
    run_stream(0, 64, 1'b0, 8'h00, cyc);
    check_output("base_cycles", cyc, 64);
    @(negedge clk);
    check_output("base_last_addr", bus.addr_write, 12'd95);
    check_output("base_avail_after", bus.avail_out, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("base_write_after", bus.write, 1'b0);
    @(posedge clk); #1;

    // Same job with valid toggling.
    push_expected(12'd32, 64, 8'h40, 64);
    apply_stimulus(12'd32, 8'd4, 16'd16);
    run_stream(0, 64, 1'b1, 8'h40, cyc);
    check_output("gap_cycles", cyc, 127);
    repeat (2) @(posedge clk);
    #1;

    // Address wrap past 4095.
    push_expected(12'd4090, 10, 8'h80, 10);
    apply_stimulus(12'd4090, 8'd1, 16'd10);
    run_stream(0, 10, 1'b0, 8'h80, cyc);
    repeat (2) @(posedge clk);
    #1;

    zero_job(8'd0, 16'd5);
    zero_job(8'd3, 16'd0);

    // Ignored configure mid-job, then reset after 10 writes.
    push_expected(12'd32, 64, 8'h10, 10);
    apply_stimulus(12'd32, 8'd4, 16'd16);
    run_stream(0, 5, 1'b0, 8'h10, cyc);
    bus.configure           = 1'b1;
    bus.base_address        = 12'd500;
    bus.num_iters           = 8'd1;
    bus.num_writes_per_iter = 16'd1;
    run_stream(5, 1, 1'b0, 8'h10, cyc);
    bus.configure = 1'b0;
    run_stream(6, 4, 1'b0, 8'h10, cyc);
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h1A;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_write", bus.write, 1'b0);
    check_output("mid_rst_avail", bus.avail_out, 1'b0);
    check_output("mid_rst_done", bus.done, 1'b0);
    check_output("mid_rst_addr", bus.addr_write, 12'd0);
    check_output("mid_rst_data", bus.data_write, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    check_output("mid_rst_sb_empty", exp_q.size(), 0);

    push_expected(12'd0, 2, 8'h20, 2);
    apply_stimulus(12'd0, 8'd1, 16'd2);
    run_stream(0, 2, 1'b0, 8'h20, cyc);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: second configure lands in the done cycle of the first.
    push_expected(12'd100, 3, 8'h30, 3);
    apply_stimulus(12'd100, 8'd1, 16'd3);
    run_stream(0, 3, 1'b0, 8'h30, cyc);
    push_expected(12'd200, 4, 8'h50, 4);
    apply_stimulus(12'd200, 8'd1, 16'd4);
    run_stream(0, 4, 1'b0, 8'h50, cyc);
    check_output("b2b_cycles", cyc, 4);

    repeat (4) @(posedge clk);
    #1;
    check_output("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
